// File: rtl/clb_cfg_loader_if.sv
`timescale 1ns/1ps
// Bit-stream input and configuration-word output of the CLB config loader.
// master = loader side, slave = bitstream source plus CLB array side.
interface clb_cfg_loader_if #(
  parameter int CFG_W  = 37,
  parameter int ADDR_W = 4
);
  logic              DIN;
  logic              DIN_VALID;
  logic              DIN_READY;
  logic [CFG_W-1:0]  CFG_DATA;
  logic [ADDR_W-1:0] CFG_ADDR;
  logic              CFG_VALID;
  logic              CFG_READY;
  logic              DONE;
  logic              ERR;
  logic [1:0]        ERR_CODE;

  modport master (
    input  DIN, DIN_VALID, CFG_READY,
    output DIN_READY, CFG_DATA, CFG_ADDR, CFG_VALID, DONE, ERR, ERR_CODE
  );

  modport slave (
    output DIN, DIN_VALID, CFG_READY,
    input  DIN_READY, CFG_DATA, CFG_ADDR, CFG_VALID, DONE, ERR, ERR_CODE
  );
endinterface

// File: rtl/clb_cfg_loader.sv
`timescale 1ns/1ps
// Serial configuration loader: checks leader/preamble/count/framing of a bitstream
// and delivers each parity-checked CLB word with its address over valid/ready.
module clb_cfg_loader #(
  parameter int         CFG_W      = 37,
  parameter int         NUM_CLB    = 9,
  parameter int         ADDR_W     = 4,
  parameter int         LEADER_MIN = 4,
  parameter logic [3:0] PREAMBLE   = 4'b0010
) (
  input logic              K,
  input logic              RSTN,
  clb_cfg_loader_if.master bus
);
  localparam int CNT_W  = $clog2(CFG_W + 1);
  localparam int ONES_W = $clog2(LEADER_MIN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_LEN, S_START, S_DATA, S_PAR, S_HOLD, S_POST, S_DONE, S_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [ONES_W-1:0] ones_cnt_reg;
  logic [CFG_W-1:0]  shift_reg;
  logic              par_reg;
  logic [ADDR_W-1:0] frame_idx_reg;
  logic [CFG_W-1:0]  cfg_data_reg;
  logic [ADDR_W-1:0] cfg_addr_reg;
  logic [1:0]        err_code_reg;

  logic       take;
  logic       leader_ok;
  logic       pre_bit;
  logic       last_frame;
  logic [7:0] len_word;

  // No bit is consumed while a word waits for the array.
  assign take       = bus.DIN_VALID && (state_reg != S_HOLD);
  assign leader_ok  = ones_cnt_reg >= ONES_W'(LEADER_MIN);
  assign pre_bit    = PREAMBLE[2'd2 - bit_cnt_reg[1:0]];
  assign last_frame = frame_idx_reg == ADDR_W'(NUM_CLB - 1);
  assign len_word   = {shift_reg[6:0], bus.DIN};

  always_ff @(posedge K) begin
    if (!RSTN) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (take && !bus.DIN && leader_ok) state_next = S_PRE;
      S_PRE:   if (take) begin
                 if (bus.DIN != pre_bit)            state_next = S_IDLE;
                 else if (bit_cnt_reg == CNT_W'(2)) state_next = S_LEN;
               end
      S_LEN:   if (take && bit_cnt_reg == CNT_W'(7))
                 state_next = (len_word != 8'(NUM_CLB)) ? S_ERROR : S_START;
      S_START: if (take) state_next = bus.DIN ? S_ERROR : S_DATA;
      S_DATA:  if (take && bit_cnt_reg == CNT_W'(CFG_W - 1)) state_next = S_PAR;
      S_PAR:   if (take) state_next = (par_reg ^ bus.DIN) ? S_ERROR : S_HOLD;
      S_HOLD:  if (bus.CFG_READY) state_next = last_frame ? S_POST : S_START;
      S_POST:  if (take) begin
                 if (!bus.DIN)                      state_next = S_ERROR;
                 else if (bit_cnt_reg == CNT_W'(3)) state_next = S_DONE;
               end
      S_DONE:  state_next = S_DONE;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge K) begin
    if (!RSTN) begin
      bit_cnt_reg   <= '0;
      ones_cnt_reg  <= '0;
      shift_reg     <= '0;
      par_reg       <= 1'b0;
      frame_idx_reg <= '0;
      cfg_data_reg  <= '0;
      cfg_addr_reg  <= '0;
      err_code_reg  <= 2'd0;
    end else begin
      // Field bit counter restarts on every state change.
      if (state_next != state_reg) bit_cnt_reg <= '0;
      else if (take)               bit_cnt_reg <= bit_cnt_reg + 1'b1;

      if (take && state_reg == S_IDLE)
        ones_cnt_reg <= !bus.DIN ? '0 : (leader_ok ? ones_cnt_reg : ones_cnt_reg + 1'b1);

      if (take && (state_reg == S_LEN || state_reg == S_DATA))
        shift_reg <= {shift_reg[CFG_W-2:0], bus.DIN};

      if (take && state_reg == S_START)     par_reg <= 1'b0;
      else if (take && state_reg == S_DATA) par_reg <= par_reg ^ bus.DIN;

      if (take && state_reg == S_PAR && state_next == S_HOLD) begin
        cfg_data_reg <= shift_reg;
        cfg_addr_reg <= frame_idx_reg;
      end

      if (state_reg == S_HOLD && bus.CFG_READY)
        frame_idx_reg <= frame_idx_reg + 1'b1;

      if (state_next == S_ERROR && state_reg != S_ERROR)
        err_code_reg <= (state_reg == S_LEN) ? 2'd1 : (state_reg == S_PAR) ? 2'd2 : 2'd3;
    end
  end

  always_comb begin
    bus.DIN_READY = (state_reg != S_HOLD);
    bus.CFG_VALID = (state_reg == S_HOLD);
    bus.DONE      = (state_reg == S_DONE);
    bus.ERR       = (state_reg == S_ERROR);
    bus.ERR_CODE  = err_code_reg;
    bus.CFG_DATA  = cfg_data_reg;
    bus.CFG_ADDR  = cfg_addr_reg;
  end
endmodule

// File: tb/tb_clb_cfg_loader.sv
`timescale 1ns/1ps
// Directed bench for clb_cfg_loader: builds bitstreams, drives them bit by bit
// and compares delivered words, addresses and status against hand-derived values.
module tb_clb_cfg_loader;
  localparam int CFG_W   = 37;
  localparam int NUM_CLB = 9;
  localparam int ADDR_W  = 4;

  logic K = 1'b0;
  logic RSTN = 1'b0;
  always #5 K = ~K;

  clb_cfg_loader_if #(.CFG_W(CFG_W), .ADDR_W(ADDR_W)) bus();

  clb_cfg_loader #(
    .CFG_W(CFG_W), .NUM_CLB(NUM_CLB), .ADDR_W(ADDR_W),
    .LEADER_MIN(4), .PREAMBLE(4'b0010)
  ) dut (
    .K(K),
    .RSTN(RSTN),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int bp_cycles = 0;
  int rdy_viol = 0;
  int base;
  int vbase;
  logic bits[$];
  bit   lat_flag[$];
  logic [CFG_W-1:0]  got_d[$];
  logic [ADDR_W-1:0] got_a[$];
  logic [5:0] p6;
  logic [7:0] p8;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Array side: CFG_READY low for bp_cycles cycles of each CFG_VALID, else high.
  initial begin
    int bp_wait;
    bp_wait = 0;
    bus.CFG_READY = 1'b1;
    forever begin
      @(negedge K);
      #1;
      if (bus.CFG_VALID === 1'b1) begin
        if (bp_wait < bp_cycles) begin
          bus.CFG_READY = 1'b0;
          bp_wait++;
        end else begin
          bus.CFG_READY = 1'b1;
        end
      end else begin
        bp_wait = 0;
        bus.CFG_READY = (bp_cycles == 0);
      end
    end
  end

  // Handshake monitor, one line per accepted word.
  initial begin
    forever begin
      @(negedge K);
      #2;
      if (RSTN && bus.CFG_VALID === 1'b1 && bus.CFG_READY === 1'b1) begin
        got_d.push_back(bus.CFG_DATA);
        got_a.push_back(bus.CFG_ADDR);
        $display("cfg word addr=%0d data=0x%h t=%0t", bus.CFG_ADDR, bus.CFG_DATA, $time);
      end
      if (bus.CFG_VALID === 1'b1 && bus.DIN_READY !== 1'b0) rdy_viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic b, input bit lat);
    bits.push_back(b);
    lat_flag.push_back(lat);
  endtask

  task automatic build(input int lead, input logic [7:0] cnt, input int flip_f,
                       input int bad_start_f, input logic [3:0] post);
    logic [CFG_W-1:0] w;
    logic p;
    logic [3:0] pre;
    pre = 4'b0010;
    bits.delete();
    lat_flag.delete();
    repeat (lead) push(1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) push(pre[i], 1'b0);
    for (int i = 7; i >= 0; i--) push(cnt[i], 1'b0);
    for (int f = 0; f < NUM_CLB; f++) begin
      w = CFG_W'(37'h116) + CFG_W'(f);
      p = ^w;
      if (f == flip_f) w[5] = ~w[5];
      push(f == bad_start_f, 1'b0);
      for (int i = CFG_W - 1; i >= 0; i--) push(w[i], 1'b0);
      push(p, f != flip_f);
    end
    for (int i = 3; i >= 0; i--) push(post[i], 1'b0);
  endtask

  task automatic send_bit(input logic b, input int gap);
    int waits;
    repeat (gap) begin
      @(negedge K);
      bus.DIN_VALID = 1'b0;
    end
    @(negedge K);
    bus.DIN = b;
    bus.DIN_VALID = 1'b1;
    waits = 0;
    while (bus.DIN_READY !== 1'b1 && waits < 200) begin
      @(negedge K);
      waits++;
    end
    if (waits >= 200) check("din_ready_timeout", 64'(bus.DIN_READY), 64'd1);
    @(posedge K);
  endtask

  task automatic send_all(input int cut, input int gapmax, input bit chk_lat);
    int n;
    int gap;
    n = (cut < 0) ? bits.size() : cut;
    for (int i = 0; i < n; i++) begin
      gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      send_bit(bits[i], gap);
      if (chk_lat && lat_flag[i]) begin
        #1;
        check($sformatf("latency.bit%0d", i), 64'(bus.CFG_VALID), 64'd1);
      end
    end
    @(negedge K);
    bus.DIN_VALID = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge K);
  endtask

  task automatic check_reset(input string t);
    check({t, ".cfg_valid"}, 64'(bus.CFG_VALID), 64'd0);
    check({t, ".cfg_data"},  64'(bus.CFG_DATA),  64'd0);
    check({t, ".cfg_addr"},  64'(bus.CFG_ADDR),  64'd0);
    check({t, ".done"},      64'(bus.DONE),      64'd0);
    check({t, ".err"},       64'(bus.ERR),       64'd0);
    check({t, ".err_code"},  64'(bus.ERR_CODE),  64'd0);
    check({t, ".din_ready"}, 64'(bus.DIN_READY), 64'd1);
  endtask

  task automatic do_reset(input bit chk, input string t);
    @(negedge K);
    RSTN = 1'b0;
    bus.DIN_VALID = 1'b0;
    repeat (2) @(negedge K);
    if (chk) check_reset(t);
    RSTN = 1'b1;
  endtask

  task automatic check_words(input string t, input int b, input int exp_n);
    check({t, ".count"}, 64'(got_d.size() - b), 64'(exp_n));
    for (int i = 0; i < exp_n && b + i < got_d.size(); i++) begin
      check($sformatf("%s.data%0d", t, i), 64'(got_d[b + i]), 64'h116 + 64'(i));
      check($sformatf("%s.addr%0d", t, i), 64'(got_a[b + i]), 64'(i));
    end
  endtask

  task automatic check_status(input string t, input logic done, input logic err,
                              input logic [1:0] code);
    check({t, ".done"},     64'(bus.DONE),     64'(done));
    check({t, ".err"},      64'(bus.ERR),      64'(err));
    check({t, ".err_code"}, 64'(bus.ERR_CODE), 64'(code));
  endtask

  initial begin
    bus.DIN = 1'b0;
    bus.DIN_VALID = 1'b0;
    do_reset(1'b1, "t0.reset");

    // Nominal load with CFG_READY held high.
    base = got_d.size();
    build(8, 8'd9, -1, -1, 4'hF);
    send_all(-1, 0, 1'b1);
    settle();
    check_words("t2", base, 9);
    check_status("t2", 1'b1, 1'b0, 2'd0);

    // Reset in the middle of frame 2's data, then a clean reload.
    do_reset(1'b0, "t1.pre");
    base = got_d.size();
    build(8, 8'd9, -1, -1, 4'hF);
    send_all(110, 0, 1'b0);
    settle();
    check_words("t1.partial", base, 2);
    do_reset(1'b1, "t1.reset");
    base = got_d.size();
    build(8, 8'd9, -1, -1, 4'hF);
    send_all(-1, 0, 1'b0);
    settle();
    check_words("t1.reload", base, 9);
    check_status("t1.reload", 1'b1, 1'b0, 2'd0);

    // Backpressure: 5 stalled cycles per word.
    bp_cycles = 5;
    do_reset(1'b0, "t3");
    base = got_d.size();
    vbase = rdy_viol;
    build(8, 8'd9, -1, -1, 4'hF);
    send_all(-1, 0, 1'b0);
    settle();
    check_words("t3", base, 9);
    check("t3.din_ready_in_hold", 64'(rdy_viol - vbase), 64'd0);
    check_status("t3", 1'b1, 1'b0, 2'd0);
    bp_cycles = 0;

    // Short leader and broken preamble fall back to IDLE silently.
    do_reset(1'b0, "t4");
    base = got_d.size();
    p6 = 6'b110010;
    for (int i = 5; i >= 0; i--) send_bit(p6[i], 0);
    @(negedge K);
    bus.DIN_VALID = 1'b0;
    settle();
    check_status("t4.short", 1'b0, 1'b0, 2'd0);
    p8 = 8'b11110011;
    for (int i = 7; i >= 0; i--) send_bit(p8[i], 0);
    @(negedge K);
    bus.DIN_VALID = 1'b0;
    settle();
    check_status("t4.badpre", 1'b0, 1'b0, 2'd0);
    build(8, 8'd9, -1, -1, 4'hF);
    send_all(-1, 0, 1'b0);
    settle();
    check_words("t4", base, 9);
    check_status("t4.final", 1'b1, 1'b0, 2'd0);

    // Error cases.
    do_reset(1'b0, "t5a");
    base = got_d.size();
    build(8, 8'd8, -1, -1, 4'hF);
    send_all(-1, 0, 1'b0);
    settle();
    check_words("t5a", base, 0);
    check_status("t5a", 1'b0, 1'b1, 2'd1);

    do_reset(1'b0, "t5b");
    base = got_d.size();
    build(8, 8'd9, 3, -1, 4'hF);
    send_all(-1, 0, 1'b0);
    settle();
    check_words("t5b", base, 3);
    check_status("t5b", 1'b0, 1'b1, 2'd2);

    do_reset(1'b0, "t5c");
    base = got_d.size();
    build(8, 8'd9, -1, 2, 4'hF);
    send_all(-1, 0, 1'b0);
    settle();
    check_words("t5c", base, 2);
    check_status("t5c", 1'b0, 1'b1, 2'd3);

    do_reset(1'b0, "t5d");
    base = got_d.size();
    build(8, 8'd9, -1, -1, 4'b1101);
    send_all(-1, 0, 1'b0);
    settle();
    check_words("t5d", base, 9);
    check_status("t5d", 1'b0, 1'b1, 2'd3);

    // Random DIN_VALID gaps between bits.
    do_reset(1'b0, "t6");
    base = got_d.size();
    build(8, 8'd9, -1, -1, 4'hF);
    send_all(-1, 7, 1'b0);
    settle();
    check_words("t6", base, 9);
    check_status("t6", 1'b1, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
